// File: rtl/fft_pkg.sv
// Shared constants, state encoding and butterfly address arithmetic for the
// in-place radix-2 FFT memory scheduler.
package fft_pkg;

  localparam int LOG_N      = 8;
  localparam int N          = 1 << LOG_N;
  localparam int BF_LAT_DEF = 2;
  localparam int SW         = $clog2(LOG_N);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_e;

  typedef struct packed {
    logic [LOG_N-1:0] a;
    logic [LOG_N-1:0] b;
    logic [LOG_N-2:0] tw;
  } bf_addr_t;

  typedef struct packed {
    logic             vld;
    logic [LOG_N-1:0] a;
    logic [LOG_N-1:0] b;
  } dl_ent_t;

  // Butterfly k of stage s: insert a zero bit at position s of k to get a.
  function automatic bf_addr_t bf_addr(input logic [SW-1:0] s, input logic [LOG_N-2:0] k);
    bf_addr_t         r;
    logic [LOG_N-1:0] h, j, g, t;
    h    = LOG_N'(1) << s;
    j    = {1'b0, k} & (h - 1'b1);
    g    = {1'b0, k} >> s;
    t    = j << (SW'(LOG_N - 1) - s);
    r.a  = ((g << s) << 1) | j;
    r.b  = r.a + h;
    r.tw = t[LOG_N-2:0];
    return r;
  endfunction

endpackage

// File: rtl/fft_mem_sched_delay_line.sv
// Carries issued (a,b) pairs to their write-back slot, DEPTH cycles after the read.
// Also yields the operand-valid strobe one cycle after each read; no backpressure.
module sched_delay_line
  import fft_pkg::*;
#(
  parameter int DEPTH = BF_LAT_DEF + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [LOG_N-1:0] a_i,
  input  logic [LOG_N-1:0] b_i,
  output logic             bf_vld_o,
  output logic             out_vld_o,
  output logic [LOG_N-1:0] out_a_o,
  output logic [LOG_N-1:0] out_b_o,
  output logic             empty_o
);

  dl_ent_t line_q [DEPTH];
  logic    bf_vld_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
      bf_vld_q <= 1'b0;
    end else begin
      line_q[0] <= '{vld: push_i, a: a_i, b: b_i};
      for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
      bf_vld_q <= line_q[0].vld;
    end
  end

  always_comb begin
    empty_o = 1'b1;
    for (int i = 0; i < DEPTH; i++) if (line_q[i].vld) empty_o = 1'b0;
  end

  assign bf_vld_o  = bf_vld_q;
  assign out_vld_o = line_q[DEPTH-1].vld;
  assign out_a_o   = line_q[DEPTH-1].a;
  assign out_b_o   = line_q[DEPTH-1].b;

endmodule

// File: rtl/fft_mem_sched.sv
// Sequences all radix-2 stages over a dual-port BRAM: reads on even cycles, write-back
// 1+BF_LAT cycles later on odd cycles; one butterfly per 2 cycles, no backpressure.
module fft_mem_sched
  import fft_pkg::*;
#(
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic [LOG_N-1:0] Stage,
  output logic             En,
  output logic             We_A,
  output logic             We_B,
  output logic [LOG_N-1:0] Addr_A,
  output logic [LOG_N-1:0] Addr_B,
  output logic [LOG_N-2:0] Tw_Addr,
  output logic             Bf_Valid
);

  state_e           state_q;
  logic [SW-1:0]    stage_q;
  logic [LOG_N-2:0] k_q;
  logic             phase_q, busy_q, done_q, en_q, we_q;
  logic [LOG_N-1:0] addr_a_q, addr_b_q;
  logic [LOG_N-2:0] tw_q;

  logic             rd_go_d;
  logic [SW-1:0]    rd_stage_d;
  logic [LOG_N-2:0] rd_k_d;
  bf_addr_t         rd_addr_d;
  logic             dl_empty, dl_vld, bf_vld;
  logic [LOG_N-1:0] dl_a, dl_b;

  // Reads are decided one cycle ahead so every port output comes straight from a flop.
  always_comb begin
    rd_go_d    = 1'b0;
    rd_stage_d = stage_q;
    rd_k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        rd_go_d    = Start;
        rd_stage_d = '0;
        rd_k_d     = '0;
      end
      S_RUN:   rd_go_d = ~phase_q;
      S_DRAIN: begin
        rd_go_d    = dl_empty && (stage_q != SW'(LOG_N - 1));
        rd_stage_d = stage_q + 1'b1;
        rd_k_d     = '0;
      end
      default: ;
    endcase
    rd_addr_d = bf_addr(rd_stage_d, rd_k_d);
  end

  sched_delay_line #(.DEPTH(BF_LAT + 1)) u_dline (
    .clk_i    (Clk),
    .rst_i    (Rst),
    .push_i   (rd_go_d),
    .a_i      (rd_addr_d.a),
    .b_i      (rd_addr_d.b),
    .bf_vld_o (bf_vld),
    .out_vld_o(dl_vld),
    .out_a_o  (dl_a),
    .out_b_o  (dl_b),
    .empty_o  (dl_empty)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      stage_q  <= '0;
      k_q      <= '0;
      phase_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
    end else begin
      done_q <= 1'b0;
      en_q   <= rd_go_d | dl_vld;
      we_q   <= ~rd_go_d & dl_vld;
      if (rd_go_d) begin
        addr_a_q <= rd_addr_d.a;
        addr_b_q <= rd_addr_d.b;
        tw_q     <= rd_addr_d.tw;
      end else if (dl_vld) begin
        addr_a_q <= dl_a;
        addr_b_q <= dl_b;
      end
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            state_q <= S_RUN;
            stage_q <= '0;
            k_q     <= LOG_N'(1);
            phase_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          phase_q <= ~phase_q;
          if (!phase_q) begin
            k_q <= k_q + 1'b1;
            if (k_q == (LOG_N-1)'(N/2 - 1)) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (dl_empty) begin
            if (stage_q == SW'(LOG_N - 1)) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_RUN;
              stage_q <= stage_q + 1'b1;
              k_q     <= LOG_N'(1);
              phase_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Stage    = {{(LOG_N-SW){1'b0}}, stage_q};
  assign En       = en_q;
  assign We_A     = we_q;
  assign We_B     = we_q;
  assign Addr_A   = addr_a_q;
  assign Addr_B   = addr_b_q;
  assign Tw_Addr  = tw_q;
  assign Bf_Valid = bf_vld;

endmodule

// File: tb/tb_fft_mem_sched.sv
// Directed bench for fft_mem_sched; instances with BF_LAT = 0, 2, 4 run in lockstep.
module tb_fft_mem_sched;
  import fft_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start;
  logic busy_w [3], done_w [3], en_w [3], wea_w [3], web_w [3], bfv_w [3];
  logic [LOG_N-1:0] stage_w [3], addra_w [3], addrb_w [3];
  logic [LOG_N-2:0] tw_w [3];
  int vectors = 0;
  int miscompares = 0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    fft_mem_sched #(.BF_LAT(2*gi)) u_dut (
      .Clk(clk), .Rst(rst), .Start(start),
      .Busy(busy_w[gi]), .Done(done_w[gi]), .Stage(stage_w[gi]),
      .En(en_w[gi]), .We_A(wea_w[gi]), .We_B(web_w[gi]),
      .Addr_A(addra_w[gi]), .Addr_B(addrb_w[gi]), .Tw_Addr(tw_w[gi]),
      .Bf_Valid(bfv_w[gi])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Butterfly k of stage s in plain arithmetic: groups of 2h, offset k mod h.
  function automatic void exp_bf(input int s, input int k, output int a, output int b, output int tw);
    int h;
    h  = 1 << s;
    a  = (k / h) * 2 * h + (k % h);
    b  = a + h;
    tw = (k % h) * (128 / h);
  endfunction

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({busy_w[i], done_w[i], en_w[i], wea_w[i], web_w[i], bfv_w[i],
           stage_w[i], addra_w[i], addrb_w[i], tw_w[i]} !== 37'd0) begin
        miscompares++;
        $display("FAIL %s dut%0d: outputs=%h required 0", tag, i,
                 {busy_w[i], done_w[i], en_w[i], wea_w[i], web_w[i], bfv_w[i],
                  stage_w[i], addra_w[i], addrb_w[i], tw_w[i]});
      end
    end
  endtask

  task automatic check_first_read(input string tag);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({en_w[i], wea_w[i], web_w[i], busy_w[i], stage_w[i], addra_w[i], addrb_w[i], tw_w[i]} !==
          {1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd1, 7'd0}) begin
        miscompares++;
        $display("FAIL %s dut%0d: en=%b we=%b%b busy=%b stage=%0d A=%0d B=%0d tw=%0d required 1 00 1 0 0 1 0",
                 tag, i, en_w[i], wea_w[i], web_w[i], busy_w[i], stage_w[i], addra_w[i], addrb_w[i], tw_w[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
  endtask

  task automatic test_first_butterfly();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_first_read("first_read");
    tick();
    vectors++;
    if (bfv_w[1] !== 1'b1 || en_w[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL cycle2 bf_valid: bfv=%b en=%b required bfv=1 en=0", bfv_w[1], en_w[1]);
    end
    tick();
    vectors++;
    if ({en_w[1], wea_w[1], addra_w[1], addrb_w[1]} !== {1'b1, 1'b0, 8'd2, 8'd3}) begin
      miscompares++;
      $display("FAIL cycle3 read k1: en=%b we=%b A=%0d B=%0d required 1 0 2 3",
               en_w[1], wea_w[1], addra_w[1], addrb_w[1]);
    end
    tick();
    vectors++;
    if ({en_w[1], wea_w[1], web_w[1], addra_w[1], addrb_w[1]} !== {1'b1, 1'b1, 1'b1, 8'd0, 8'd1}) begin
      miscompares++;
      $display("FAIL cycle4 write: en=%b we=%b%b A=%0d B=%0d required 1 11 0 1",
               en_w[1], wea_w[1], web_w[1], addra_w[1], addrb_w[1]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Every read/write is checked against its absolute scheduled cycle; poke pulses Start mid-run.
  task automatic test_full_run(input int poke);
    int reads [3], writes [3], bfvs [3], done_at [3], prev_rd [3];
    int c, lat, per, rr, s, off, k, ea, eb, etw, last_done;
    bit ok, finished;
    for (int i = 0; i < 3; i++) begin
      reads[i] = 0; writes[i] = 0; bfvs[i] = 0; done_at[i] = 0; prev_rd[i] = -10;
    end
    finished = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    while (c < 2300 && !finished) begin
      for (int i = 0; i < 3; i++) begin
        lat = 2 * i;
        per = N + lat;
        if (en_w[i] === 1'b1 && wea_w[i] === 1'b0) begin
          rr  = c - 1;
          s   = rr / per;
          off = rr % per;
          ok  = (off % 2 == 0) && (off < N) && (s < LOG_N);
          k   = off / 2;
          exp_bf(s, k, ea, eb, etw);
          if (ok && off == 0 && s > 0) begin
            vectors++;
            if (writes[i] != 128 * s) begin
              miscompares++;
              $display("FAIL hazard dut%0d stage %0d: writes done=%0d required %0d", i, s, writes[i], 128 * s);
            end
          end
          vectors++;
          if (!ok || web_w[i] !== 1'b0 || busy_w[i] !== 1'b1 || stage_w[i] !== LOG_N'(s) ||
              addra_w[i] !== LOG_N'(ea) || addrb_w[i] !== LOG_N'(eb) || tw_w[i] !== (LOG_N-1)'(etw)) begin
            miscompares++;
            $display("FAIL read dut%0d cycle %0d: slot_ok=%0d stage=%0d A=%0d B=%0d tw=%0d required stage=%0d A=%0d B=%0d tw=%0d",
                     i, c, ok, stage_w[i], addra_w[i], addrb_w[i], tw_w[i], s, ea, eb, etw);
          end
          if (i == 1 && ok && s == 3 && k == 9) begin
            vectors++;
            if ({addra_w[i], addrb_w[i], tw_w[i]} !== {8'd17, 8'd25, 7'd16}) begin
              miscompares++;
              $display("FAIL addr s3k9: A=%0d B=%0d tw=%0d required 17 25 16", addra_w[i], addrb_w[i], tw_w[i]);
            end
          end
          if (i == 1 && ok && s == 7 && k == 5) begin
            vectors++;
            if ({addra_w[i], addrb_w[i], tw_w[i]} !== {8'd5, 8'd133, 7'd5}) begin
              miscompares++;
              $display("FAIL addr s7k5: A=%0d B=%0d tw=%0d required 5 133 5", addra_w[i], addrb_w[i], tw_w[i]);
            end
          end
          reads[i]++;
          prev_rd[i] = c;
        end
        if (en_w[i] === 1'b1 && wea_w[i] === 1'b1) begin
          rr  = c - 2 - lat;
          s   = (rr >= 0) ? rr / per : 99;
          off = (rr >= 0) ? rr % per : 1;
          ok  = (rr >= 0) && (off % 2 == 0) && (off < N) && (s < LOG_N);
          exp_bf(ok ? s : 0, off / 2, ea, eb, etw);
          vectors++;
          if (!ok || web_w[i] !== 1'b1 || addra_w[i] !== LOG_N'(ea) || addrb_w[i] !== LOG_N'(eb)) begin
            miscompares++;
            $display("FAIL write dut%0d cycle %0d: slot_ok=%0d weB=%b A=%0d B=%0d required A=%0d B=%0d",
                     i, c, ok, web_w[i], addra_w[i], addrb_w[i], ea, eb);
          end
          writes[i]++;
        end
        if (bfv_w[i] === 1'b1) begin
          vectors++;
          if (prev_rd[i] != c - 1) begin
            miscompares++;
            $display("FAIL bf_valid dut%0d cycle %0d: last read at %0d required %0d", i, c, prev_rd[i], c - 1);
          end
          bfvs[i]++;
        end
        if (done_w[i] === 1'b1) begin
          vectors++;
          if (c != 1 + LOG_N * per || busy_w[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL done dut%0d: cycle=%0d busy=%b required cycle=%0d busy=0", i, c, busy_w[i], 1 + LOG_N * per);
          end
          done_at[i] = c;
        end
      end
      last_done = (done_at[0] > done_at[1]) ? done_at[0] : done_at[1];
      last_done = (done_at[2] > last_done) ? done_at[2] : last_done;
      if (done_at[0] != 0 && done_at[1] != 0 && done_at[2] != 0 && c >= last_done + 8) finished = 1'b1;
      start = (c == poke) ? 1'b1 : 1'b0;
      if (!finished) begin
        tick();
        c++;
      end
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      per = N + 2 * i;
      vectors++;
      if (reads[i] != 1024 || writes[i] != 1024 || bfvs[i] != 1024 || done_at[i] != 1 + LOG_N * per) begin
        miscompares++;
        $display("FAIL totals dut%0d: reads=%0d writes=%0d bfv=%0d done_at=%0d required 1024 1024 1024 %0d",
                 i, reads[i], writes[i], bfvs[i], done_at[i], 1 + LOG_N * per);
      end
      vectors++;
      if (en_w[i] !== 1'b0 || busy_w[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_after_done dut%0d: en=%b busy=%b required 0 0", i, en_w[i], busy_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (1 + 4 * 258 + 36) tick();
    rst = 1'b1;
    tick();
    check_all_zero("reset_mid");
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (en_w[i] !== 1'b0 || busy_w[i] !== 1'b0) begin
          miscompares++;
          $display("FAIL post_reset_quiet dut%0d cycle %0d: en=%b busy=%b required 0 0", i, n, en_w[i], busy_w[i]);
        end
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check_first_read("restart");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_first_butterfly();
    test_full_run(0);
    test_full_run(600);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
